// File: rtl/sequence_checker_16bit.sv
// sequence_checker_16bit
//
// Watches the low byte of an external incrementing counter and reports
// whether the checker has locked onto it and how many sequence errors
// it has seen while locked.
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   io_in[0]      rst : synchronous, active-high, used without a register stage
//   io_in[1]      en  : sample strobe
//   io_in[9:2]    data: observed counter byte
//   io_in[15:10]  ignored
//   io_out[9:0]   constant 0
//   io_out[10]    locked
//   io_out[11]    err_sticky
//   io_out[15:12] err_cnt (saturating)
//   io_oeb        constant 16'h03FF (pins 9..0 inputs, 15..10 outputs)
//
// Latency: a sample presented on io_in at edge N is captured into
// en_q/data_q at N, acted on by the checker at N+1, and shows up on
// io_out after the output register at N+2.

module sequence_checker_16bit (
  input  logic        clk,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Pin decode
  logic       rst;
  logic       en;
  logic [7:0] data;
  logic       unused_pins;

  assign rst         = io_in[0];
  assign en          = io_in[1];
  assign data        = io_in[9:2];
  assign unused_pins = ^io_in[15:10];

  // Input stage
  logic       en_q;
  logic [7:0] data_q;

  // Checker state
  state_t     state,      state_d;
  logic [7:0] expected,   expected_d;
  logic [1:0] match_cnt,  match_cnt_d;
  logic       miss_cnt,   miss_cnt_d;
  logic       err_sticky, err_sticky_d;
  logic [3:0] err_cnt,    err_cnt_d;

  // Output register and its comb source
  logic       locked_o,   locked_o_d;
  logic       sticky_o,   sticky_o_d;
  logic [3:0] cnt_o,      cnt_o_d;

  logic       match;
  assign match = (data_q == expected);

  // ---------------------------------------------------------------------
  // Process 1: state register (input stage, checker, output stage)
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      data_q     <= 8'h00;
      state      <= UNLOCKED;
      expected   <= 8'h00;
      match_cnt  <= 2'd0;
      miss_cnt   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= 4'h0;
      locked_o   <= 1'b0;
      sticky_o   <= 1'b0;
      cnt_o      <= 4'h0;
    end else begin
      en_q       <= en;
      data_q     <= data;
      state      <= state_d;
      expected   <= expected_d;
      match_cnt  <= match_cnt_d;
      miss_cnt   <= miss_cnt_d;
      err_sticky <= err_sticky_d;
      err_cnt    <= err_cnt_d;
      locked_o   <= locked_o_d;
      sticky_o   <= sticky_o_d;
      cnt_o      <= cnt_o_d;
    end
  end

  // ---------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every output of this block is given its hold value first, so no
  // path through the case statement can leave one unassigned (no latches).
  always_comb begin
    state_d      = state;
    expected_d   = expected;
    match_cnt_d  = match_cnt;
    miss_cnt_d   = miss_cnt;
    err_sticky_d = err_sticky;
    err_cnt_d    = err_cnt;

    if (en_q) begin
      // Always resync to the observed value, whatever the state.
      expected_d = data_q + 8'd1;

      unique case (state)
        UNLOCKED: begin
          state_d     = LOCKING;
          match_cnt_d = 2'd0;
        end

        LOCKING: begin
          if (!match) begin
            match_cnt_d = 2'd0;
          end else if (match_cnt == 2'd2) begin
            // Third consecutive match after the capture sample.
            state_d     = LOCKED;
            match_cnt_d = 2'd0;
          end else begin
            match_cnt_d = match_cnt + 2'd1;
          end
        end

        LOCKED: begin
          if (match) begin
            miss_cnt_d = 1'b0;
          end else begin
            err_sticky_d = 1'b1;
            if (err_cnt != 4'hF) begin
              err_cnt_d = err_cnt + 4'd1;
            end
            if (miss_cnt) begin
              // Second mismatch in a row: lock is lost.
              state_d    = UNLOCKED;
              miss_cnt_d = 1'b0;
            end else begin
              miss_cnt_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = UNLOCKED;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Process 3: output logic (feeds the output register)
  // ---------------------------------------------------------------------
  always_comb begin
    locked_o_d = (state == LOCKED);
    sticky_o_d = err_sticky;
    cnt_o_d    = err_cnt;
  end

  assign io_out = {cnt_o, sticky_o, locked_o, 10'b0};
  assign io_oeb = 16'h03FF;

endmodule
